// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package   : cpu_defs
// Purpose   : Shared encodings for the fetch unit: next-PC select codes,
//             halt opcode and fetch state encoding.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
package cpu_defs;

  // Next-PC select values driven by the control unit on PCSrc
  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pc_src_e;

  // Opcode that stops instruction fetch
  localparam logic [5:0] HALT_OP = 6'b111111;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HALT  = 2'b10
  } fetch_state_e;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : pc_fetch_unit_if
// Purpose   : Fetch-side bus between the fetch unit (master) and the
//             instruction memory (slave): address/read request out, decoded
//             instruction fields back.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic [31:0] IAddr;
  logic        RW;
  logic [5:0]  op;
  logic [15:0] Immediate;
  logic [25:0] JumpAddr;

  modport master (
    output IAddr,
    output RW,
    input  op,
    input  Immediate,
    input  JumpAddr
  );

  modport slave (
    input  IAddr,
    input  RW,
    output op,
    output Immediate,
    output JumpAddr
  );
endinterface : pc_fetch_unit_if
`default_nettype wire

// File: rtl/pc_fetch_unit_next_pc_calc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module    : next_pc_calc
// Purpose   : Purely combinational next-PC generator. Produces PC+4, the
//             selected next PC and a flag when that PC is outside the legal
//             fetch window or misaligned.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
module next_pc_calc
  import cpu_defs::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  wire logic [31:0] i_pc,
  input  wire logic [1:0]  i_pc_src,
  input  wire logic [15:0] i_imm,
  input  wire logic [25:0] i_jump_addr,
  input  wire logic [31:0] i_reg_addr,
  output logic      [31:0] o_next_pc,
  output logic      [31:0] o_pc4,
  output logic             o_illegal
);

  // Highest address at which a full word can still be fetched
  localparam logic [31:0] C_MAX_PC = 32'(MEM_BYTES - 4);

  logic [31:0] w_branch_off;
  logic        w_misaligned;

  assign o_pc4        = i_pc + 32'd4;
  assign w_branch_off = {{14{i_imm[15]}}, i_imm, 2'b00};

  // Select the candidate next PC; all arithmetic wraps modulo 2^32
  always_comb begin
    o_next_pc    = o_pc4;
    w_misaligned = 1'b0;
    case (pc_src_e'(i_pc_src))
      PC_NEXT:   o_next_pc = o_pc4;
      PC_BRANCH: o_next_pc = o_pc4 + w_branch_off;
      PC_JUMP:   o_next_pc = {o_pc4[31:28], i_jump_addr, 2'b00};
      PC_REG: begin
        o_next_pc    = i_reg_addr;
        w_misaligned = (i_reg_addr[1:0] != 2'b00);
      end
      default:   o_next_pc = o_pc4;
    endcase
  end

  // Negative branch results wrap high and so also fail the range test
  assign o_illegal = w_misaligned || (o_next_pc > C_MAX_PC);

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module    : pc_fetch_unit
// Purpose   : Instruction-fetch initiator. Owns the PC, issues a read to the
//             instruction memory every FETCH cycle, advances the PC on
//             PCWre, and tracks halt, address-error and retired-fetch count.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [5:0]  HALT_OP   = cpu_defs::HALT_OP
) (
  input  wire logic        CLK,
  input  wire logic        Reset,
  input  wire logic        PCWre,
  input  wire logic [1:0]  PCSrc,
  input  wire logic [31:0] RegAddr,
  pc_fetch_unit_if.master  imem,
  output logic      [31:0] PC4,
  output logic             Halted,
  output logic             AddrErr,
  output logic      [31:0] InstCount
);

  import cpu_defs::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_inst_cnt;
  logic [31:0]  w_inst_cnt_nxt;
  logic         r_addr_err;
  logic         w_addr_err_nxt;

  logic [31:0]  w_calc_pc;
  logic         w_calc_illegal;

  next_pc_calc #(
    .MEM_BYTES (MEM_BYTES)
  ) u_next_pc_calc (
    .i_pc        (r_pc),
    .i_pc_src    (PCSrc),
    .i_imm       (imem.Immediate),
    .i_jump_addr (imem.JumpAddr),
    .i_reg_addr  (RegAddr),
    .o_next_pc   (w_calc_pc),
    .o_pc4       (PC4),
    .o_illegal   (w_calc_illegal)
  );

  // State, PC, counter and sticky error register; reset overrides everything
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst_cnt <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst_cnt <= w_inst_cnt_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  // Next-state logic: halt opcode wins over PCWre, a bad target halts with error
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_cnt_nxt = r_inst_cnt;
    w_addr_err_nxt = r_addr_err;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem.op == HALT_OP) begin
          w_state_nxt = S_HALT;
        end else if (PCWre) begin
          if (w_calc_illegal) begin
            w_state_nxt    = S_HALT;
            w_addr_err_nxt = 1'b1;
          end else begin
            w_pc_nxt       = w_calc_pc;
            w_inst_cnt_nxt = r_inst_cnt + 32'd1;
          end
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch is issued straight from the PC register so memory sees it at zero latency
  assign imem.IAddr = r_pc;
  assign imem.RW    = (r_state == S_FETCH);
  assign Halted     = (r_state == S_HALT);
  assign AddrErr    = r_addr_err;
  assign InstCount  = r_inst_cnt;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module    : tb_pc_fetch_unit
// Purpose   : Directed self-checking bench for pc_fetch_unit.
// Revision  : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] RegAddr;
  logic [31:0] PC4;
  logic        Halted;
  logic        AddrErr;
  logic [31:0] InstCount;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (128),
    .HALT_OP   (6'b111111)
  ) dut (
    .CLK       (clk),
    .Reset     (rst),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .RegAddr   (RegAddr),
    .imem      (imem_bus.master),
    .PC4       (PC4),
    .Halted    (Halted),
    .AddrErr   (AddrErr),
    .InstCount (InstCount)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full observable status in one call
  task automatic check_all(input string tag, input logic [31:0] addr, input logic rw,
                           input logic halt, input logic err, input logic [31:0] cnt);
    check_eq({tag, ".IAddr"},     imem_bus.IAddr,  addr);
    check_eq({tag, ".RW"},        {31'd0, imem_bus.RW}, {31'd0, rw});
    check_eq({tag, ".Halted"},    {31'd0, Halted}, {31'd0, halt});
    check_eq({tag, ".AddrErr"},   {31'd0, AddrErr}, {31'd0, err});
    check_eq({tag, ".InstCount"}, InstCount, cnt);
    check_eq({tag, ".PC4"},       PC4, addr + 32'd4);
  endtask

  // Reset for one cycle, leaving the DUT in IDLE with Reset released
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    PCWre              = 1'b1;
    PCSrc              = 2'b00;
    RegAddr            = 32'd0;
    imem_bus.op        = 6'd0;
    imem_bus.Immediate = 16'd0;
    imem_bus.JumpAddr  = 26'd0;

    // 1: two reset cycles, then sequential fetch
    tick();
    tick();
    rst = 1'b0;
    check_all("rst_idle", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    check_all("fetch0", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    check_all("fetch4", 32'd4, 1'b1, 1'b0, 1'b0, 32'd1);
    tick();
    check_all("fetch8", 32'd8, 1'b1, 1'b0, 1'b0, 32'd2);

    // 2: branches from PC=8
    PCSrc = 2'b01; imem_bus.Immediate = 16'hFFFF;
    tick();
    check_all("br_m1", 32'd8, 1'b1, 1'b0, 1'b0, 32'd3);
    imem_bus.Immediate = 16'h0003;
    tick();
    check_all("br_p3", 32'd24, 1'b1, 1'b0, 1'b0, 32'd4);

    // 3: reach PC=4, jump, then register jump
    PCSrc = 2'b11; RegAddr = 32'd4;
    tick();
    check_all("jr4", 32'd4, 1'b1, 1'b0, 1'b0, 32'd5);
    PCSrc = 2'b10; imem_bus.JumpAddr = 26'd10;
    tick();
    check_all("jmp10", 32'd40, 1'b1, 1'b0, 1'b0, 32'd6);
    PCSrc = 2'b11; RegAddr = 32'd12;
    tick();
    check_all("jr12", 32'd12, 1'b1, 1'b0, 1'b0, 32'd7);

    // 4: stall for three cycles, then resume
    PCWre = 1'b0; PCSrc = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall", 32'd12, 1'b1, 1'b0, 1'b0, 32'd7);
    end
    PCWre = 1'b1;
    tick();
    check_all("resume", 32'd16, 1'b1, 1'b0, 1'b0, 32'd8);

    // 5a: misaligned register target halts with error, PC held
    PCSrc = 2'b11; RegAddr = 32'd6;
    tick();
    check_all("jr_misal", 32'd16, 1'b0, 1'b1, 1'b1, 32'd8);
    PCSrc = 2'b00; RegAddr = 32'd0;
    tick();
    check_all("err_hold", 32'd16, 1'b0, 1'b1, 1'b1, 32'd8);

    // 5b: from PC=0, branch by -1 lands on 0 (legal), by -2 wraps negative (illegal)
    do_reset();
    check_all("rst_err", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    PCSrc = 2'b01; imem_bus.Immediate = 16'hFFFF;
    tick();
    check_all("br0_m1", 32'd0, 1'b1, 1'b0, 1'b0, 32'd1);
    imem_bus.Immediate = 16'hFFFE;
    tick();
    check_all("br0_m2", 32'd0, 1'b0, 1'b1, 1'b1, 32'd1);

    // 5c: top of memory: 124 is legal, the next sequential fetch (128) is not
    do_reset();
    tick();
    PCSrc = 2'b11; RegAddr = 32'd124;
    tick();
    check_all("jr124", 32'd124, 1'b1, 1'b0, 1'b0, 32'd1);
    PCSrc = 2'b00;
    tick();
    check_all("pc128", 32'd124, 1'b0, 1'b1, 1'b1, 32'd1);

    // 6: halt opcode at PC=20 beats PCWre, then reset mid-halt
    do_reset();
    tick();
    PCSrc = 2'b11; RegAddr = 32'd20;
    tick();
    check_all("jr20", 32'd20, 1'b1, 1'b0, 1'b0, 32'd1);
    PCSrc = 2'b00; imem_bus.op = 6'b111111;
    tick();
    check_all("halt", 32'd20, 1'b0, 1'b1, 1'b0, 32'd1);
    imem_bus.op = 6'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("halt_hold", 32'd20, 1'b0, 1'b1, 1'b0, 32'd1);
    end

    // Reset with PCWre and a register jump active must still win
    PCSrc = 2'b11; RegAddr = 32'd40; PCWre = 1'b1;
    do_reset();
    check_all("rst_halt", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    PCSrc = 2'b00;
    tick();
    check_all("refetch", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
